// File: rtl/stk_pipe_al_chk.sv
// stk_pipe_al_chk: sweeps every line of a memory once and checks it against EXP_DATA,
// tracking read latency with a valid/address shift pipe aligned to the returning data.
module stk_pipe_al_chk #(
    parameter int N = 256,
    parameter int RD_LAT = 1,
    parameter logic [127:0] EXP_DATA = '0,
    localparam int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_start,
    output logic          o_chk_ren_r,
    output logic [AW-1:0] o_chk_raddr_r,
    input  logic [127:0]  i_chk_rdata,
    output logic          o_busy_r,
    output logic          o_done_r,
    output logic          o_err_r,
    output logic [AW-1:0] o_err_addr_r,
    output logic [AW:0]   o_err_cnt_r
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    logic [1:0] state_q, state_d;
    logic [RD_LAT-1:0] pv_q;
    logic [AW-1:0] pa_q [RD_LAT];
    logic last, mism;
    always_comb begin
        last = o_chk_raddr_r == AW'(N - 1);
        mism = pv_q[RD_LAT-1] && i_chk_rdata != EXP_DATA;
        state_d = i_start ? ISSUE :
                  (state_q == ISSUE && last) ? DRAIN :
                  (state_q == DRAIN && pv_q == '0) ? DONE :
                  (state_q == DONE) ? IDLE : state_q;
    end
    // A restart flushes the pipe so in-flight reads of the old sweep are never compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pv_q          <= '0;
            o_chk_ren_r   <= 1'b0;
            o_chk_raddr_r <= '0;
            o_busy_r      <= 1'b0;
            o_done_r      <= 1'b0;
            o_err_r       <= 1'b0;
            o_err_addr_r  <= '0;
            o_err_cnt_r   <= '0;
        end else begin
            state_q       <= state_d;
            pv_q          <= i_start ? '0 : RD_LAT'({pv_q, o_chk_ren_r});
            o_chk_ren_r   <= state_d == ISSUE;
            o_chk_raddr_r <= i_start ? '0 : o_chk_raddr_r + AW'(state_q == ISSUE && !last);
            o_busy_r      <= state_d == ISSUE || state_d == DRAIN;
            o_done_r      <= state_d == DONE;
            if (i_start) begin
                o_err_r      <= 1'b0;
                o_err_addr_r <= '0;
                o_err_cnt_r  <= '0;
            end else if (mism) begin
                o_err_cnt_r <= o_err_cnt_r + 1'b1;
                if (!o_err_r) begin
                    o_err_r      <= 1'b1;
                    o_err_addr_r <= pa_q[RD_LAT-1];
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        pa_q[0] <= o_chk_raddr_r;
        for (int k = 1; k < RD_LAT; k++) pa_q[k] <= pa_q[k-1];
    end
endmodule

// File: tb/tb_stk_pipe_al_chk.sv
// tb_stk_pipe_al_chk: three checkers (RD_LAT 2, 1, 4) over one shared 8-line memory model,
// driven by a vector table, corner-case sequences and randomized contents.
module tb_stk_pipe_al_chk;
    localparam int N = 8;
    logic clk = 0, rst = 1, i_start = 0;
    logic [2:0] ren, busy, done, err;
    logic [2:0][2:0] raddr, eaddr;
    logic [2:0][3:0] ecnt;
    logic [127:0] mem [N];
    logic [127:0] d2 [2], d1 [1], d4 [4];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    stk_pipe_al_chk #(.N(N), .RD_LAT(2)) u_l2 (.clk(clk), .rst(rst), .i_start(i_start),
        .o_chk_ren_r(ren[0]), .o_chk_raddr_r(raddr[0]), .i_chk_rdata(d2[1]), .o_busy_r(busy[0]),
        .o_done_r(done[0]), .o_err_r(err[0]), .o_err_addr_r(eaddr[0]), .o_err_cnt_r(ecnt[0]));
    stk_pipe_al_chk #(.N(N), .RD_LAT(1)) u_l1 (.clk(clk), .rst(rst), .i_start(i_start),
        .o_chk_ren_r(ren[1]), .o_chk_raddr_r(raddr[1]), .i_chk_rdata(d1[0]), .o_busy_r(busy[1]),
        .o_done_r(done[1]), .o_err_r(err[1]), .o_err_addr_r(eaddr[1]), .o_err_cnt_r(ecnt[1]));
    stk_pipe_al_chk #(.N(N), .RD_LAT(4)) u_l4 (.clk(clk), .rst(rst), .i_start(i_start),
        .o_chk_ren_r(ren[2]), .o_chk_raddr_r(raddr[2]), .i_chk_rdata(d4[3]), .o_busy_r(busy[2]),
        .o_done_r(done[2]), .o_err_r(err[2]), .o_err_addr_r(eaddr[2]), .o_err_cnt_r(ecnt[2]));

    // Memory model: data appears RD_LAT cycles after the enable cycle; idle slots carry junk.
    always @(posedge clk) begin
        d2[0] <= ren[0] ? mem[raddr[0]] : '1;
        d2[1] <= d2[0];
        d1[0] <= ren[1] ? mem[raddr[1]] : '1;
        d4[0] <= ren[2] ? mem[raddr[2]] : '1;
        for (int k = 1; k < 4; k++) d4[k] <= d4[k-1];
    end

    function automatic int lat(input int i);
        return i == 0 ? 2 : i == 1 ? 1 : 4;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill(input logic [7:0] mask, input int bitpos);
        logic [127:0] one;
        one = '0;
        one[bitpos] = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = mask[i] ? one : '0;
    endtask

    // Pulse start, watch 40 cycles, compare against sweep-level expectations.
    task automatic run_sweep(input string tag, input int e_err, input int e_addr, input int e_cnt);
        int nb [3], nd [3], se [3], sa [3], sc [3];
        int nr;
        bit seq;
        nr = 0;
        seq = 1;
        for (int i = 0; i < 3; i++) begin
            nb[i] = 0; nd[i] = 0; se[i] = 99; sa[i] = 99; sc[i] = 99;
        end
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        chk({tag, " cleared cnt"}, ecnt[0], 0);
        chk({tag, " first addr"}, raddr[0], 0);
        for (int c = 0; c < 40; c++) begin
            if (ren[0]) begin
                if (raddr[0] != 3'(nr)) seq = 0;
                nr++;
            end
            for (int i = 0; i < 3; i++) begin
                if (busy[i]) nb[i]++;
                if (done[i]) begin
                    nd[i]++; se[i] = err[i]; sa[i] = eaddr[i]; sc[i] = ecnt[i];
                end
            end
            @(negedge clk);
        end
        chk({tag, " addr seq"}, seq, 1);
        chk({tag, " reads"}, nr, N);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s L%0d done", tag, lat(i)), nd[i], 1);
            chk($sformatf("%s L%0d busy", tag, lat(i)), nb[i], N + lat(i) + 1);
            chk($sformatf("%s L%0d err", tag, lat(i)), se[i], e_err);
            chk($sformatf("%s L%0d eaddr", tag, lat(i)), sa[i], e_addr);
            chk($sformatf("%s L%0d ecnt", tag, lat(i)), sc[i], e_cnt);
            chk($sformatf("%s L%0d hold", tag, lat(i)), ecnt[i], e_cnt);
        end
    endtask

    typedef struct {
        logic [7:0] mask;
        int bitpos, e_err, e_addr, e_cnt;
    } vec_t;

    initial begin
        vec_t tbl [4];
        int cnt, first, hit;
        logic [7:0] m;
        tbl[0] = '{8'h00, 0, 0, 0, 0};
        tbl[1] = '{8'h48, 5, 1, 3, 2};
        tbl[2] = '{8'hff, 127, 1, 0, 8};
        tbl[3] = '{8'h80, 64, 1, 7, 1};
        fill(8'h00, 0);
        repeat (3) @(negedge clk);
        chk("reset ren", ren, 0);
        chk("reset busy", busy, 0);
        chk("reset err", err, 0);
        chk("reset cnt", ecnt[0], 0);
        rst = 0;
        repeat (3) @(negedge clk);
        chk("idle busy", busy, 0);
        chk("idle ren", ren, 0);

        for (int t = 0; t < 4; t++) begin
            fill(tbl[t].mask, tbl[t].bitpos);
            run_sweep($sformatf("vec%0d", t), tbl[t].e_err, tbl[t].e_addr, tbl[t].e_cnt);
        end

        // Restart mid-issue: line 1 bad only on the first pass.
        fill(8'h02, 9);
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (ren[0] && raddr[0] == 3'd5) hit = 1;
            else @(negedge clk);
        end
        chk("restart reached addr5", hit, 1);
        chk("restart pre err", err[0], 1);
        fill(8'h00, 0);
        run_sweep("restart", 0, 0, 0);

        // Reset during DRAIN abandons the sweep.
        fill(8'h04, 3);
        i_start = 1;
        @(negedge clk);
        i_start = 0;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (busy[0] && !ren[0]) hit = 1;
            else @(negedge clk);
        end
        chk("drain reached", hit, 1);
        chk("drain err seen", err[0], 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rst ren", ren[0], 0);
        chk("rst raddr", raddr[0], 0);
        chk("rst busy", busy[0], 0);
        chk("rst done", done[0], 0);
        chk("rst err", err[0], 0);
        chk("rst eaddr", eaddr[0], 0);
        chk("rst ecnt", ecnt[0], 0);
        hit = 0;
        for (int c = 0; c < 20; c++) begin
            if (done != 0 || busy != 0) hit++;
            @(negedge clk);
        end
        chk("no done after rst", hit, 0);
        fill(8'h00, 0);
        run_sweep("post rst", 0, 0, 0);

        // Reset wins over a simultaneous start.
        rst = 1;
        i_start = 1;
        @(negedge clk);
        rst = 0;
        i_start = 0;
        @(negedge clk);
        chk("rst over start", busy, 0);

        // Randomized contents against a count/first-index model.
        for (int r = 0; r < 6; r++) begin
            m = 8'($urandom);
            for (int i = 0; i < N; i++) begin
                mem[i] = '0;
                if (m[i]) mem[i][$urandom_range(127)] = 1'b1;
            end
            cnt = 0;
            first = -1;
            for (int i = 0; i < N; i++) if (mem[i] != '0) begin
                cnt++;
                if (first < 0) first = i;
            end
            run_sweep($sformatf("rnd%0d", r), cnt > 0, first < 0 ? 0 : first, cnt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stk_pipe_al_chk.md
STK_PIPE_AL_CHK -- requirements
Module: stk_pipe_al_chk

Interface
REQ-001 The module SHALL have parameter N, default 256, giving the number of lines in the line memory; the address width is AW = $clog2(N).
REQ-002 The module SHALL have parameter RD_LAT, default 1, range 1..4, giving the memory read latency in cycles from a read-enable cycle to its data cycle.
REQ-003 The module SHALL have parameter EXP_DATA, 128 bits, default all-zero, giving the expected contents of every line.
REQ-004 Port clk, input, 1 bit: the only clock; all state SHALL update on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port i_start, input, 1 bit: single-cycle pulse that starts or restarts a check sweep.
REQ-007 Port o_chk_ren_r, output, 1 bit: registered memory read enable.
REQ-008 Port o_chk_raddr_r, output, AW bits: registered memory read address (stk_pkg::line_id_t).
REQ-009 Port i_chk_rdata, input, 128 bits: memory read data, valid exactly RD_LAT cycles after the cycle in which o_chk_ren_r is high.
REQ-010 Port o_busy_r, output, 1 bit: a sweep is in progress.
REQ-011 Port o_done_r, output, 1 bit: one-cycle pulse when a sweep completes.
REQ-012 Port o_err_r, output, 1 bit: sticky flag, at least one mismatch in the current or last sweep.
REQ-013 Port o_err_addr_r, output, AW bits: address of the first mismatching line.
REQ-014 Port o_err_cnt_r, output, AW+1 bits: number of mismatching lines.

Function
REQ-015 The state machine SHALL have exactly four states: IDLE, ISSUE, DRAIN and DONE.
REQ-016 In IDLE, with i_start=1, the next state SHALL be ISSUE; the read address SHALL load 0; o_err_r, o_err_addr_r and o_err_cnt_r SHALL clear to 0; the in-flight pipe SHALL clear.
REQ-017 In ISSUE, o_chk_ren_r SHALL be 1, and o_chk_raddr_r SHALL increment by 1 each cycle starting from 0.
REQ-018 When ISSUE issues address N-1, the next state SHALL be DRAIN; exactly N reads SHALL be issued per sweep, each address 0..N-1 exactly once, with no wrap-around.
REQ-019 The block SHALL carry a valid bit plus address through an RD_LAT-deep shift pipe aligned to each read.
REQ-020 A pipe entry emerging valid SHALL compare i_chk_rdata against EXP_DATA, all 128 bits.
REQ-021 DRAIN SHALL last until the pipe is empty (RD_LAT cycles after the last read), then transition to DONE.
REQ-022 In DONE, o_done_r SHALL be 1 for exactly one cycle, then the state SHALL return to IDLE.
REQ-023 o_busy_r SHALL be 1 exactly when the state is ISSUE or DRAIN, registered so that it is high the cycle after i_start.
REQ-024 On a mismatch, o_err_cnt_r SHALL increment by 1; it cannot overflow, because at most N mismatches occur per sweep.
REQ-025 On the first mismatch of a sweep (o_err_r=0), o_err_addr_r SHALL capture the entry address and o_err_r SHALL set; later mismatches SHALL NOT update o_err_addr_r.
REQ-026 Error outputs SHALL hold after DONE until the next i_start or reset.
REQ-027 i_start while in ISSUE, DRAIN or DONE SHALL restart the sweep as in REQ-016: in-flight reads are discarded uncompared, the address returns to 0 and errors clear; i_start has priority over every other transition.
REQ-028 In IDLE without i_start, o_chk_ren_r SHALL be 0 and no comparison SHALL occur.
REQ-029 A sweep from start to done SHALL take exactly N+RD_LAT+1 cycles of o_busy_r high, with o_done_r high on the following cycle.

Reset
REQ-030 When rst=1, the state SHALL become IDLE, and o_chk_ren_r, o_chk_raddr_r, o_busy_r, o_done_r, o_err_r, o_err_addr_r, o_err_cnt_r and all pipe valid bits SHALL become 0 on the next edge.
REQ-031 rst SHALL override i_start in the same cycle.
REQ-032 Reset mid-sweep SHALL abandon the sweep with no o_done_r pulse.
REQ-033 After reset, the block SHALL be idle until i_start.

Verification
REQ-034 Scenario (N=8, RD_LAT=2, memory all zero): i_start pulse -> o_chk_raddr_r 0..7 on consecutive cycles with o_chk_ren_r=1; o_done_r pulse; o_err_r=0; o_err_cnt_r=0.
REQ-035 Scenario (lines 3 and 6 nonzero): sweep -> o_err_r=1, o_err_addr_r=3, o_err_cnt_r=2.
REQ-036 Scenario (all 8 lines bit 127 set): sweep -> o_err_cnt_r=8 (no overflow), o_err_addr_r=0.
REQ-037 Scenario (i_start re-pulsed while issuing address 5, line 1 bad on first pass only): -> address restarts at 0; errors cleared; final o_err_r=0; single o_done_r pulse.
REQ-038 Scenario (rst asserted during DRAIN): -> all outputs 0 next cycle; no o_done_r; a new i_start then runs a full clean sweep.
REQ-039 Scenario (RD_LAT=1 and RD_LAT=4, error on line N-1): -> mismatch captured at o_err_addr_r=N-1, before o_done_r.
